terminal_rx: RTL and testbench

Serial receiver for the terminal link. It recovers 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit, idle high) from the single-wire line driven by the terminal transmitter, using the same baud period. Each byte is presented on a valid/ready holding register to the downstream consumer, with one-cycle pulses for framing errors and overruns.

---
 rtl/terminal_pkg.sv | 15 +
 rtl/terminal_rx_sync2.sv | 24 ++
 rtl/terminal_rx.sv | 160 ++++++++++++++++
 tb/tb_terminal_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/terminal_pkg.sv
// Shared definitions for the terminal serial link.
package terminal_pkg;

  localparam int unsigned TERMINAL_CLKS_PER_BIT = 1303;
  localparam int unsigned TERMINAL_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/terminal_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // Shift the input through two flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/terminal_rx.sv
// 8N1 serial receiver with a valid/ready holding register.
module terminal_rx
  import terminal_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = TERMINAL_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned DW   = TERMINAL_DATA_BITS;
  localparam int unsigned BW   = $clog2(TERMINAL_DATA_BITS);

  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(DW - 1);

  logic rx_s;

  rx_state_t     state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [DW-1:0] shreg_q,   shreg_d;
  logic [DW-1:0] data_q,    data_d;
  logic          valid_q,   valid_d;
  logic          ferr_q,    ferr_d;
  logic          ovr_q,     ovr_d;
  logic          deliver;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Receive sequencing, bit sampling and holding-register update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    deliver   = 1'b0;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            cnt_d     = CNT_FULL;
            bit_idx_d = '0;
            state_d   = DATA;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_s, shreg_q[DW-1:1]};
          cnt_d   = CNT_FULL;
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A delivery in the same cycle as an acceptance overrides the clear.
    if (deliver) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_terminal_rx.sv
module tb_terminal_rx;
  import terminal_pkg::*;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  logic       rx2 = 1'b1;
  logic       rx_ready2 = 1'b1;
  logic [7:0] rx_data2;
  logic       rx_valid2, frame_err2, overrun2, busy2;

  always #5 clk = ~clk;

  terminal_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  terminal_rx u_dut_dflt (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx2),
    .rx_data  (rx_data2),
    .rx_valid (rx_valid2),
    .rx_ready (rx_ready2),
    .frame_err(frame_err2),
    .overrun  (overrun2),
    .busy     (busy2)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned fall;
  int unsigned n;
  int          ferr_seen = 0;
  int          ovr_seen  = 0;
  int          exp_ferr  = 0;
  int          exp_ovr   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_byte;
  logic [7:0]  b;
  logic        ok;
  int unsigned gap;
  logic [11:0] pat;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every accepted byte must match the next expected one.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: actual %02h, required no byte", rx_data);
        end else begin
          exp_byte = exp_q.pop_front();
          if (rx_data !== exp_byte) begin
            errors++;
            $display("FAIL rx_byte: actual %02h, required %02h", rx_data, exp_byte);
          end
        end
      end
      if (frame_err) ferr_seen++;
      if (overrun)   ovr_seen++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int unsigned k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_line(input int line, input logic v);
    if (line == 0) rx = v;
    else           rx2 = v;
  endtask

  // Line is left low after a low stop bit; the caller releases it.
  task automatic send_frame(input int line, input logic [7:0] d, input logic stop,
                            input int unsigned cpb);
    drive_line(line, 1'b0);
    wait_cyc(cpb);
    for (int i = 0; i < 8; i++) begin
      drive_line(line, d[i]);
      wait_cyc(cpb);
    end
    drive_line(line, stop);
    wait_cyc(cpb);
    if (stop) drive_line(line, 1'b1);
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b1;
    wait_cyc(5);

    // Single frame with exact delivery latency
    exp_q.push_back(8'hA5);
    fall = cyc;
    fork
      send_frame(0, 8'hA5, 1'b1, CPB);
      begin
        n = 0;
        while (!rx_valid && n < 300) begin
          @(negedge clk);
          n++;
        end
        chk("a5_valid", rx_valid, 1);
        chk("a5_latency", cyc - fall, 155);
        @(negedge clk);
        chk("a5_valid_pulse", rx_valid, 0);
      end
    join
    wait_cyc(5);
    chk("a5_no_frame_err", ferr_seen, 0);
    chk("a5_drained", exp_q.size(), 0);

    // Back-to-back frames
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    send_frame(0, 8'h55, 1'b1, CPB);
    send_frame(0, 8'h0F, 1'b1, CPB);
    wait_cyc(10);
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_overrun", ovr_seen, exp_ovr);

    // Framing error followed by a held-low line
    send_frame(0, 8'h3C, 1'b0, CPB);
    exp_ferr++;
    wait_cyc(40);
    rx = 1'b1;
    wait_cyc(20);
    chk("ferr_count", ferr_seen, exp_ferr);
    chk("ferr_no_valid", rx_valid, 0);
    exp_q.push_back(8'h81);
    send_frame(0, 8'h81, 1'b1, CPB);
    wait_cyc(10);
    chk("after_break_drained", exp_q.size(), 0);

    // Short low glitch on the idle line
    fall = cyc;
    rx = 1'b0;
    wait_cyc(5);
    rx = 1'b1;
    wait_cyc(5);
    @(negedge clk);
    chk("glitch_busy_before", busy, 1);
    @(negedge clk);
    chk("glitch_busy_drop", busy, 0);
    wait_cyc(20);
    chk("glitch_no_valid", rx_valid, 0);

    // Overrun with the consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(0, 8'h11, 1'b1, CPB);
    send_frame(0, 8'h22, 1'b1, CPB);
    exp_ovr++;
    wait_cyc(10);
    chk("ovr_data_kept", rx_data, 8'h11);
    chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_count", ovr_seen, exp_ovr);
    rx_ready = 1'b1;
    wait_cyc(2);
    chk("ovr_valid_cleared", rx_valid, 0);
    chk("ovr_drained", exp_q.size(), 0);

    // Reset in the middle of a frame
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      wait_cyc(CPB);
    end
    wait_cyc(CPB / 2);
    rst = 1'b0;
    wait_cyc(2);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b1;
    wait_cyc(CPB * 6);
    exp_q.push_back(8'h7E);
    send_frame(0, 8'h7E, 1'b1, CPB);
    wait_cyc(10);
    chk("midrst_next_frame", exp_q.size(), 0);

    // Randomized frames with occasional bad stop bits
    for (int k = 0; k < 40; k++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 7) != 0);
      gap = $urandom_range(0, 12);
      if (ok) exp_q.push_back(b);
      else    exp_ferr++;
      send_frame(0, b, ok, CPB);
      if (!ok) begin
        wait_cyc(3);
        rx = 1'b1;
        gap = gap + 4;
      end
      wait_cyc(gap);
    end
    wait_cyc(20);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_frame_err", ferr_seen, exp_ferr);
    chk("rand_overrun", ovr_seen, exp_ovr);

    // Default baud period with a rotating 12-bit pattern source
    pat = 12'hA5C;
    for (int k = 0; k < 2; k++) begin
      b = pat[7:0];
      fork
        send_frame(1, b, 1'b1, TERMINAL_CLKS_PER_BIT);
        begin
          n = 0;
          while (!rx_valid2 && n < 15000) begin
            @(negedge clk);
            n++;
          end
          chk("loop_valid", rx_valid2, 1);
          chk("loop_byte", rx_data2, b);
        end
      join
      pat = {pat[10:0], pat[11]};
    end
    chk("loop_frame_err", frame_err2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
